rr_mem_arbiter: RTL and testbench

Round-robin arbiter sharing one single-port data memory between CORE_NUM shader cores in the videocard. Serves one transaction at a time over a request/response handshake and sequences the fixed memory read latency. Routes read data back to the granted core. Sits between the per-core data ports and the external memory port of the videocard top.

---
 rtl/videocard_pkg.sv | 16 +
 rtl/rr_mem_arbiter_picker.sv | 31 +++
 rtl/rr_mem_arbiter.sv | 119 +++++++++++
 tb/tb_rr_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/videocard_pkg.sv
// Shared videocard definitions: default bus geometry and the memory arbiter
// state encoding.
package videocard_pkg;

   localparam int WIDTH_DEF    = 32;
   localparam int CORE_NUM_DEF = 4;
   localparam int IDX_W        = $clog2(CORE_NUM_DEF);

   typedef logic [1:0] arb_state_t;

   localparam arb_state_t IDLE  = 2'd0;
   localparam arb_state_t ISSUE = 2'd1;
   localparam arb_state_t WAIT  = 2'd2;
   localparam arb_state_t RESP  = 2'd3;

endpackage

// File: rtl/rr_mem_arbiter_picker.sv
// Round-robin request picker. It rotates the request vector so that rr_ptr
// sits at bit 0, then takes the lowest set bit of the rotated vector.
module rr_priority_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  request,
   input  logic [IW-1:0] rr_ptr,
   output logic          found,
   output logic [IW-1:0] index
);

   logic [N-1:0] rotated;

   always_comb begin
      rotated = '0;
      index   = '0;
      for (int k = 0; k < N; k++) begin
         rotated[k] = request[(int'(rr_ptr) + k) % N];
      end
      // Descending scan, so the lowest rotated position is the last to write.
      for (int k = N - 1; k >= 0; k--) begin
         if (rotated[k]) begin
            index = IW'((int'(rr_ptr) + k) % N);
         end
      end
   end

   assign found = |request;

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter giving CORE_NUM cores one transaction at a time on a
// shared single-port memory with a fixed read latency.
//
// state | meaning
// IDLE  | no transaction; pick the next requester from rr_ptr onward
// ISSUE | address/data on the memory port; wren pulses here on writes
// WAIT  | read in flight; capture data_read when the counter reaches 0
// RESP  | response pulse to the granted core; rr_ptr moves past it
module rr_mem_arbiter
   import videocard_pkg::*;
#(
   parameter int  WIDTH      = WIDTH_DEF,
   parameter int  CORE_NUM   = CORE_NUM_DEF,
   parameter int  RD_LATENCY = 2,
   localparam int IW         = $clog2(CORE_NUM)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CORE_NUM-1:0]       request,
   input  logic [CORE_NUM-1:0]       wren_core,
   input  logic [CORE_NUM*WIDTH-1:0] address_in,
   input  logic [CORE_NUM*WIDTH-1:0] data_in,
   output logic [CORE_NUM*WIDTH-1:0] data_out,
   output logic [CORE_NUM-1:0]       response,
   output logic [WIDTH-1:0]          address,
   output logic [WIDTH-1:0]          data_write,
   output logic                      wren,
   input  logic [WIDTH-1:0]          data_read,
   output logic                      busy,
   output logic [IW-1:0]             grant_idx
);

   localparam logic [3:0] WAIT_INIT = 4'(RD_LATENCY - 1);

   arb_state_t       state;
   logic [IW-1:0]    rr_ptr;
   logic [3:0]       wait_cnt;
   logic             is_write;
   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic [WIDTH-1:0] addr_arr [CORE_NUM];
   logic [WIDTH-1:0] wdata_arr [CORE_NUM];
   logic [WIDTH-1:0] dout_q [CORE_NUM];

   for (genvar gi = 0; gi < CORE_NUM; gi++) begin : g_lanes
      assign addr_arr[gi]                  = address_in[gi*WIDTH +: WIDTH];
      assign wdata_arr[gi]                 = data_in[gi*WIDTH +: WIDTH];
      assign data_out[gi*WIDTH +: WIDTH]   = dout_q[gi];
   end

   rr_priority_picker #(.N(CORE_NUM), .IW(IW)) u_picker (
      .request (request),
      .rr_ptr  (rr_ptr),
      .found   (pick_found),
      .index   (pick_idx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         grant_idx  <= '0;
         wait_cnt   <= '0;
         is_write   <= 1'b0;
         address    <= '0;
         data_write <= '0;
         wren       <= 1'b0;
         busy       <= 1'b0;
         response   <= '0;
         for (int i = 0; i < CORE_NUM; i++) begin
            dout_q[i] <= '0;
         end
      end else begin
         response <= '0;
         wren     <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_found) begin
                  grant_idx  <= pick_idx;
                  address    <= addr_arr[pick_idx];
                  data_write <= wdata_arr[pick_idx];
                  is_write   <= wren_core[pick_idx];
                  wren       <= wren_core[pick_idx];
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (is_write) begin
                  response[grant_idx] <= 1'b1;
                  state               <= RESP;
               end else begin
                  wait_cnt <= WAIT_INIT;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) begin
                  dout_q[grant_idx]   <= data_read;
                  response[grant_idx] <= 1'b1;
                  state               <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            RESP: begin
               rr_ptr <= (grant_idx == IW'(CORE_NUM - 1)) ? '0 : grant_idx + 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Scoreboard bench for rr_mem_arbiter: a transaction-level model predicts each
// grant and its timing, a negedge monitor compares the DUT against it.
module tb_rr_mem_arbiter;

   localparam int W   = 32;
   localparam int N   = 4;
   localparam int LAT = 2;

   typedef struct {
      int           core;
      bit           wr;
      logic [W-1:0] addr;
      logic [W-1:0] data;
      int           issue_cyc;
      int           resp_cyc;
   } txn_t;

   typedef struct {
      bit           wr;
      logic [W-1:0] addr;
      logic [W-1:0] data;
   } stim_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [N-1:0]   request = '0, wren_core = '0;
   logic [N*W-1:0] address_in = '0, data_in = '0, data_out;
   logic [N-1:0]   response;
   logic [W-1:0]   address, data_write;
   logic [W-1:0]   data_read = '0;
   logic           wren, busy;
   logic [1:0]     grant_idx;

   rr_mem_arbiter #(.WIDTH(W), .CORE_NUM(N), .RD_LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset), .request(request), .wren_core(wren_core),
      .address_in(address_in), .data_in(data_in), .data_out(data_out),
      .response(response), .address(address), .data_write(data_write),
      .wren(wren), .data_read(data_read), .busy(busy), .grant_idx(grant_idx)
   );

   // Latency sweep instances: read-only, driven directly by the main sequence
   logic [N-1:0]   sw_req_l1 = '0, sw_req_l5 = '0, sw_wren = '0;
   logic [N*W-1:0] sw_addr_in = '0, sw_data_in = '0;
   logic [N*W-1:0] sw_dout_l1, sw_dout_l5;
   logic [N-1:0]   sw_resp_l1, sw_resp_l5;
   logic [W-1:0]   sw_addr_l1, sw_addr_l5, sw_wd_l1, sw_wd_l5;
   logic [W-1:0]   sw_rd_l1 = '0, sw_rd_l5 = '0;
   logic           sw_wren_l1, sw_wren_l5, sw_busy_l1, sw_busy_l5;
   logic [1:0]     sw_gi_l1, sw_gi_l5;

   rr_mem_arbiter #(.WIDTH(W), .CORE_NUM(N), .RD_LATENCY(1)) u_l1 (
      .clk(clk), .reset(reset), .request(sw_req_l1), .wren_core(sw_wren),
      .address_in(sw_addr_in), .data_in(sw_data_in), .data_out(sw_dout_l1),
      .response(sw_resp_l1), .address(sw_addr_l1), .data_write(sw_wd_l1),
      .wren(sw_wren_l1), .data_read(sw_rd_l1), .busy(sw_busy_l1), .grant_idx(sw_gi_l1)
   );

   rr_mem_arbiter #(.WIDTH(W), .CORE_NUM(N), .RD_LATENCY(5)) u_l5 (
      .clk(clk), .reset(reset), .request(sw_req_l5), .wren_core(sw_wren),
      .address_in(sw_addr_in), .data_in(sw_data_in), .data_out(sw_dout_l5),
      .response(sw_resp_l5), .address(sw_addr_l5), .data_write(sw_wd_l5),
      .wren(sw_wren_l5), .data_read(sw_rd_l5), .busy(sw_busy_l5), .grant_idx(sw_gi_l5)
   );

   function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   // Memory devices: address sampled at each edge, data appears LAT cycles later
   logic [W-1:0] devmem [logic [W-1:0]];
   logic [W-1:0] pipe_m [LAT];
   logic [W-1:0] pipe_l1;
   logic [W-1:0] pipe_l5 [5];

   initial begin
      for (int k = 0; k < LAT; k++) pipe_m[k] = '0;
      for (int k = 0; k < 5; k++) pipe_l5[k] = '0;
      pipe_l1 = '0;
   end

   always @(posedge clk) begin
      if (wren) devmem[address] = data_write;
      for (int k = LAT - 1; k > 0; k--) pipe_m[k] = pipe_m[k-1];
      pipe_m[0] = address;
      for (int k = 4; k > 0; k--) pipe_l5[k] = pipe_l5[k-1];
      pipe_l5[0] = sw_addr_l5;
      pipe_l1 = sw_addr_l1;
   end

   always @(negedge clk) begin
      data_read = devmem.exists(pipe_m[LAT-1]) ? devmem[pipe_m[LAT-1]] : init_val(pipe_m[LAT-1]);
      sw_rd_l1  = init_val(pipe_l1);
      sw_rd_l5  = init_val(pipe_l5[4]);
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: one transaction at a time, write takes 3 cycles
   // (grant, issue, response), read adds LAT wait cycles.
   txn_t         exp_q[$];
   logic [W-1:0] refmem [logic [W-1:0]];
   int cyc = 0, rem = 0, mptr = 0;

   always @(posedge clk) begin
      int   g;
      txn_t t;
      if (reset) begin
         exp_q.delete();
         rem  = 0;
         mptr = 0;
      end else if (rem > 0) begin
         rem--;
      end else if (request != '0) begin
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && request[(mptr + k) % N]) g = (mptr + k) % N;
         t.core = g;
         t.wr   = wren_core[g];
         t.addr = address_in[g*W +: W];
         if (t.wr) begin
            t.data = data_in[g*W +: W];
            refmem[t.addr] = t.data;
         end else begin
            t.data = refmem.exists(t.addr) ? refmem[t.addr] : init_val(t.addr);
         end
         t.issue_cyc = cyc + 1;
         t.resp_cyc  = t.wr ? cyc + 2 : cyc + 2 + LAT;
         exp_q.push_back(t);
         rem  = t.wr ? 2 : 2 + LAT;
         mptr = (g + 1) % N;
      end
      cyc++;
   end

   // Core drivers
   stim_t script [N][$];
   int raise_pct = 100, keep_pct = 100;

   task automatic present(input int i);
      stim_t s;
      s = script[i].pop_front();
      request[i]           = 1'b1;
      wren_core[i]         = s.wr;
      address_in[i*W +: W] = s.addr;
      data_in[i*W +: W]    = s.data;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         request = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (request[i] && response[i]) begin
               if (script[i].size() > 0 && $urandom_range(99) < keep_pct) present(i);
               else request[i] = 1'b0;
            end else if (!request[i] && script[i].size() > 0 && $urandom_range(99) < raise_pct) begin
               present(i);
            end
         end
      end
   end

   // Monitor
   bit           mon_en = 1'b0;
   logic [W-1:0] mon_dout [N];
   int           served_q[$];

   initial for (int i = 0; i < N; i++) mon_dout[i] = '0;

   always @(negedge clk) begin
      bit           have, at_issue, at_resp;
      logic [N-1:0] exp_resp;
      if (mon_en) begin
         have     = exp_q.size() > 0;
         at_issue = have && cyc == exp_q[0].issue_cyc;
         at_resp  = have && cyc == exp_q[0].resp_cyc;
         chk("busy", W'(busy), W'(have && cyc >= exp_q[0].issue_cyc));
         if (at_issue) begin
            chk("issue_address", address, exp_q[0].addr);
            chk("issue_wren", W'(wren), W'(exp_q[0].wr));
            if (exp_q[0].wr) chk("issue_data_write", data_write, exp_q[0].data);
         end else begin
            chk("wren_quiet", W'(wren), '0);
         end
         if (have && cyc > exp_q[0].issue_cyc) chk("address_hold", address, exp_q[0].addr);
         exp_resp = at_resp ? N'(1 << exp_q[0].core) : '0;
         chk("response", W'(response), W'(exp_resp));
         if (at_resp) begin
            chk("grant_idx", W'(grant_idx), W'(exp_q[0].core));
            if (!exp_q[0].wr) mon_dout[exp_q[0].core] = exp_q[0].data;
            served_q.push_back(exp_q[0].core);
            void'(exp_q.pop_front());
         end
         if (reset) begin
            for (int i = 0; i < N; i++) mon_dout[i] = '0;
         end else begin
            for (int i = 0; i < N; i++) chk($sformatf("data_out%0d", i), data_out[i*W +: W], mon_dout[i]);
         end
      end
   end

   function automatic bit scripts_empty();
      for (int i = 0; i < N; i++) if (script[i].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push(input int i, input bit wr, input logic [W-1:0] a, input logic [W-1:0] d);
      stim_t s;
      s.wr = wr; s.addr = a; s.data = d;
      script[i].push_back(s);
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (n < 4000 && !(exp_q.size() == 0 && request == '0 && scripts_empty() && !busy));
      chk({nm, "_drain"}, W'(n < 4000), W'(1));
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      int base, lat1, lat5, n;
      int exp_order[8];
      logic [W-1:0] d1, d5;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_address", address, '0);
      chk("rst_data_write", data_write, '0);
      chk("rst_grant_idx", W'(grant_idx), '0);

      // Latency sweep: core1 reads 0x80 on the RD_LATENCY=1 and =5 instances
      @(posedge clk); #1;
      sw_addr_in[1*W +: W] = 32'h80;
      sw_req_l1 = 4'b0010;
      sw_req_l5 = 4'b0010;
      lat1 = -1; lat5 = -1; d1 = '0; d5 = '0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sw_resp_l1[1] && lat1 < 0) begin lat1 = k; d1 = sw_dout_l1[1*W +: W]; sw_req_l1 = '0; end
         if (sw_resp_l5[1] && lat5 < 0) begin lat5 = k; d5 = sw_dout_l5[1*W +: W]; sw_req_l5 = '0; end
      end
      chk("sweep_l1_latency", W'(lat1), 32'd3);
      chk("sweep_l5_latency", W'(lat5), 32'd7);
      chk("sweep_l1_data", d1, init_val(32'h80));
      chk("sweep_l5_data", d5, init_val(32'h80));
      chk("sweep_l1_other", sw_dout_l1[0 +: W], '0);

      // Reset during the read's WAIT phase
      @(posedge clk); #1;
      push(1, 1'b0, 32'h20, '0);
      n = 0;
      do begin @(negedge clk); n++; end while (!busy && n < 20);
      chk("midrd_busy_seen", W'(busy), W'(1));
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("midrd_busy", W'(busy), '0);
      chk("midrd_wren", W'(wren), '0);
      chk("midrd_response", W'(response), '0);
      chk("midrd_dout1", data_out[1*W +: W], '0);
      @(posedge clk); #1 reset = 1'b0;
      base = served_q.size();
      push(3, 1'b0, 32'h24, '0);
      drain("post_reset");
      chk("post_reset_grant", W'(served_q.size() > base ? served_q[base] : -1), 32'd3);

      // Single write, then a write/read pair through the memory
      base = served_q.size();
      push(2, 1'b1, 32'h40, 32'hDEADBEEF);
      drain("single_write");
      chk("single_write_grant", W'(served_q.size() > base ? served_q[base] : -1), 32'd2);
      push(0, 1'b1, 32'h10, 32'h12345678);
      drain("prep_write");
      push(1, 1'b0, 32'h10, '0);
      drain("single_read");
      chk("single_read_data", data_out[1*W +: W], 32'h12345678);
      chk("single_read_keep3", data_out[3*W +: W], init_val(32'h24));

      // Contention from reset: order 0,1,2,3,0,1,2,3
      pulse_reset();
      @(posedge clk); #1;
      base = served_q.size();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 1'b0, 32'h200 + 32'(i*16 + r*4), '0);
      drain("contention");
      exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
      chk("contention_count", W'(served_q.size() - base), 32'd8);
      for (int k = 0; k < 8; k++)
         if (served_q.size() > base + k)
            chk($sformatf("contention_order%0d", k), W'(served_q[base+k]), W'(exp_order[k]));

      // Fairness: cores 0 and 3 both continuous, must alternate
      base = served_q.size();
      for (int r = 0; r < 3; r++) begin
         push(0, 1'b1, 32'h300 + 32'(r*4), $urandom);
         push(3, 1'b0, 32'h300 + 32'(r*4), '0);
      end
      drain("fairness");
      chk("fairness_count", W'(served_q.size() - base), 32'd6);
      for (int k = 0; k < 6; k++)
         if (served_q.size() > base + k)
            chk($sformatf("fairness_order%0d", k), W'(served_q[base+k]), (k % 2 == 0) ? 32'd0 : 32'd3);

      // Random traffic on a small address window
      raise_pct = 40;
      keep_pct  = 50;
      @(posedge clk); #1;
      for (int r = 0; r < 30; r++)
         for (int i = 0; i < N; i++)
            push(i, 1'($urandom_range(1)), 32'h100 + 32'($urandom_range(7) * 4), $urandom);
      drain("random");

      repeat (10) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog time=%0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
